renkon_pool_linebuf: RTL and testbench

//  Line buffer feeding the pooling unit. Accepts a raster-order feature map stream
//  one pixel per valid cycle and presents the current MAXPOOL x MAXPOOL window,

---
 rtl/renkon_pkg.sv | 36 +++
 rtl/renkon_pool_linebuf_if.sv | 32 +++
 rtl/renkon_linebuf_ram.sv | 25 ++
 rtl/renkon_pool_linebuf.sv | 159 +++++++++++++++
 tb/tb_renkon_pool_linebuf.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/renkon_pkg.sv
// renkon_pkg: shared widths, the signed pixel type, the line-buffer FSM
// encoding and the size-clamping helpers used when a new map is armed.
package renkon_pkg;

    localparam int DWIDTH  = 16;                      // pixel width, signed
    localparam int MAXPOOL = 3;                       // largest pool window edge
    localparam int MAXFEA  = 32;                      // largest feature map edge
    localparam int LWIDTH  = $clog2(MAXFEA + 1);      // holds sizes 0..MAXFEA
    localparam int AWIDTH  = $clog2(MAXFEA);          // row memory address
    localparam int NROW    = MAXPOOL - 1;             // number of row memories
    localparam int RPWIDTH = (NROW > 1) ? $clog2(NROW) : 1;

    typedef logic signed [DWIDTH-1:0] pix_t;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } lb_state_t;

    // Window edges of 0 or beyond MAXPOOL fall back to the full window.
    function automatic logic [LWIDTH-1:0] clamp_pool(input logic [LWIDTH-1:0] size);
        if (size == '0 || size > LWIDTH'(MAXPOOL)) begin
            return LWIDTH'(MAXPOOL);
        end
        return size;
    endfunction

    // Map edges beyond the row memory depth are limited to that depth.
    function automatic logic [LWIDTH-1:0] clamp_fea(input logic [LWIDTH-1:0] size);
        if (size > LWIDTH'(MAXFEA)) begin
            return LWIDTH'(MAXFEA);
        end
        return size;
    endfunction

endpackage

// File: rtl/renkon_pool_linebuf_if.sv
// renkon_pool_linebuf_if: stream and window bus between the pool controller /
// conv output (master) and the pooling line buffer (slave).
//
// Handshake: there is no backpressure. pixel_in is consumed on every rising
// clk edge where pixel_valid is high (and the buffer is active, with no
// buf_feat_req in the same cycle). buf_feat/buf_valid update one cycle after
// each consumed pixel and hold otherwise; buf_valid marks a complete window.
// buf_feat_req is a single-cycle pulse that samples w_fea_size and pool_size.
interface renkon_pool_linebuf_if;
    import renkon_pkg::*;

    logic                               buf_feat_req;
    logic [LWIDTH-1:0]                  w_fea_size;
    logic [LWIDTH-1:0]                  pool_size;
    logic                               pixel_valid;
    pix_t                               pixel_in;
    logic [MAXPOOL*MAXPOOL*DWIDTH-1:0]  buf_feat;
    logic                               buf_valid;
    logic                               buf_busy;
    lb_state_t                          dbg_state;

    modport master (
        output buf_feat_req, w_fea_size, pool_size, pixel_valid, pixel_in,
        input  buf_feat, buf_valid, buf_busy, dbg_state
    );

    modport slave (
        input  buf_feat_req, w_fea_size, pool_size, pixel_valid, pixel_in,
        output buf_feat, buf_valid, buf_busy, dbg_state
    );

endinterface

// File: rtl/renkon_linebuf_ram.sv
// renkon_linebuf_ram: one row of the line buffer. Single port, MAXFEA deep,
// asynchronous read so the old contents at addr are seen in the same cycle
// the new pixel is written (read-before-write).
module renkon_linebuf_ram
    import renkon_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [AWIDTH-1:0] addr,
    input  pix_t              wdata,
    output pix_t              rdata
);

    pix_t mem [MAXFEA];

    assign rdata = mem[addr];

    // Write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/renkon_pool_linebuf.sv
// renkon_pool_linebuf: raster-order line buffer presenting the current
// MAXPOOL x MAXPOOL window (newest pixel bottom-right, row 0 oldest) to the
// pooling datapath. Armed by buf_feat_req; walks one map then idles.
// Build option RENKON_POOLBUF_ZEROPAD_EN: when defined, window entries left
// of column 0 or above row 0 of the map are forced to zero; otherwise they
// carry stale data and only buf_valid qualifies the window.
module renkon_pool_linebuf
    import renkon_pkg::*;
(
    input  logic                  clk,
    input  logic                  xrst,
    renkon_pool_linebuf_if.slave  bus
);

    lb_state_t          state_q, state_d;
    logic [LWIDTH-1:0]  x_q, y_q, fea_q, pool_q;
    logic [RPWIDTH-1:0] rptr_q, rptr_inc;
    logic               valid_q, valid_d;
    pix_t               win_q [MAXPOOL][MAXPOOL];
    pix_t               win_d [MAXPOOL][MAXPOOL];
    pix_t               rd    [NROW];
    pix_t               col   [MAXPOOL];
    logic [NROW-1:0]    row_we;
    logic               px_go, x_last, y_last;

    // A request in the same cycle wins over the pixel, which is dropped.
    assign px_go    = (state_q == S_ACTIVE) && bus.pixel_valid && !bus.buf_feat_req;
    assign x_last   = (x_q == fea_q - LWIDTH'(1));
    assign y_last   = (y_q == fea_q - LWIDTH'(1));
    assign rptr_inc = (rptr_q == RPWIDTH'(NROW - 1)) ? '0 : rptr_q + RPWIDTH'(1);

    // Physical row memory holding logical row i (0 = oldest line).
    function automatic logic [RPWIDTH-1:0] phys_row(input logic [RPWIDTH-1:0] ptr, input int i);
        int p;
        p = int'(ptr) + i;
        if (p >= NROW) begin
            p = p - NROW;
        end
        return RPWIDTH'(p);
    endfunction

    for (genvar k = 0; k < NROW; k++) begin : g_row
        renkon_linebuf_ram u_ram (
            .clk   (clk),
            .we    (row_we[k]),
            .addr  (x_q[AWIDTH-1:0]),
            .wdata (bus.pixel_in),
            .rdata (rd[k])
        );
    end

    // Incoming column oldest-first, and the write strobe for the oldest row.
    always_comb begin
        row_we = '0;
        for (int i = 0; i < NROW; i++) begin
            col[i] = rd[phys_row(rptr_q, i)];
        end
        col[MAXPOOL-1] = bus.pixel_in;
        for (int k = 0; k < NROW; k++) begin
            row_we[k] = px_go && (rptr_q == RPWIDTH'(k));
        end
    end

    // Next-state logic: arm on a non-empty request, idle after the last pixel.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.buf_feat_req && bus.w_fea_size != '0) begin
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (bus.buf_feat_req) begin
                    // A zero-size restart has no map to walk.
                    state_d = (bus.w_fea_size != '0) ? S_ACTIVE : S_IDLE;
                end else if (px_go && x_last && y_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Next window: shift left one column, append the new column on the right.
    always_comb begin
        for (int r = 0; r < MAXPOOL; r++) begin
            for (int c = 0; c < MAXPOOL - 1; c++) begin
                win_d[r][c] = win_q[r][c+1];
            end
        end
        for (int r = 0; r < MAXPOOL; r++) begin
            win_d[r][MAXPOOL-1] = col[r];
        end
`ifdef RENKON_POOLBUF_ZEROPAD_EN
        // Entry (r,c) covers map pixel (x-(MAXPOOL-1-c), y-(MAXPOOL-1-r)).
        for (int r = 0; r < MAXPOOL; r++) begin
            for (int c = 0; c < MAXPOOL; c++) begin
                if ((x_q < LWIDTH'(MAXPOOL - 1 - c)) || (y_q < LWIDTH'(MAXPOOL - 1 - r))) begin
                    win_d[r][c] = '0;
                end
            end
        end
`endif
        valid_d = (x_q >= pool_q - LWIDTH'(1)) && (y_q >= pool_q - LWIDTH'(1));
    end

    // State, raster position, row rotation and registered window.
    always_ff @(posedge clk) begin
        if (xrst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            rptr_q  <= '0;
            fea_q   <= '0;
            pool_q  <= '0;
            valid_q <= 1'b0;
            for (int r = 0; r < MAXPOOL; r++) begin
                for (int c = 0; c < MAXPOOL; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            if (bus.buf_feat_req) begin
                fea_q  <= clamp_fea(bus.w_fea_size);
                pool_q <= clamp_pool(bus.pool_size);
                x_q    <= '0;
                y_q    <= '0;
                rptr_q <= '0;
            end else if (px_go) begin
                valid_q <= valid_d;
                win_q   <= win_d;
                if (x_last) begin
                    x_q    <= '0;
                    rptr_q <= rptr_inc;
                    y_q    <= y_last ? '0 : y_q + LWIDTH'(1);
                end else begin
                    x_q <= x_q + LWIDTH'(1);
                end
            end
        end
    end

    // Flatten the window as index r*MAXPOOL+c.
    always_comb begin
        bus.buf_feat = '0;
        for (int r = 0; r < MAXPOOL; r++) begin
            for (int c = 0; c < MAXPOOL; c++) begin
                bus.buf_feat[(r*MAXPOOL + c)*DWIDTH +: DWIDTH] = win_q[r][c];
            end
        end
    end

    assign bus.buf_valid = valid_q;
    assign bus.buf_busy  = (state_q == S_ACTIVE);
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_renkon_pool_linebuf.sv
// tb_renkon_pool_linebuf: directed scenarios for the pooling line buffer.
// Expected entry layout: [0] buf_valid, [1] buf_busy, [2] fresh window,
// [3 +: 9] compare mask per window entry, [12 +: 144] window values.
module tb_renkon_pool_linebuf;
    import renkon_pkg::*;

    localparam int NWIN  = MAXPOOL * MAXPOOL;
    localparam int OFF_M = 3;
    localparam int OFF_W = OFF_M + NWIN;
    localparam int EW    = OFF_W + NWIN * DWIDTH;

    // clock / reset
    logic clk = 1'b0;
    logic xrst;
    always #5 clk = ~clk;

    renkon_pool_linebuf_if bus ();

    renkon_pool_linebuf dut (
        .clk  (clk),
        .xrst (xrst),
        .bus  (bus)
    );

    // scoreboard state
    logic [EW-1:0] exp_q[$];
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   valid_cnt = 0;
    logic acc       = 1'b0;
    logic gap_chk   = 1'b0;

    // reference model of the map being streamed
    pix_t          img [MAXFEA][MAXFEA];
    int            mx, my, m_fs, m_ps;
    bit            m_active;
    logic [EW-1:0] m_last;

    function automatic logic [EW-1:0] reset_entry();
        logic [EW-1:0] e;
        e = '0;
        e[OFF_M +: NWIN] = '1;
        return e;
    endfunction

    function automatic logic [EW-1:0] build_exp(input int x, input int y);
        logic [EW-1:0] e;
        int cx, cy, idx;
        bit inmap, corner;
        logic v;
        e = '0;
        v = (x >= m_ps - 1) && (y >= m_ps - 1);
        e[0] = v;
        e[2] = 1'b1;
        for (int r = 0; r < MAXPOOL; r++) begin
            for (int c = 0; c < MAXPOOL; c++) begin
                cx = x - (MAXPOOL - 1 - c);
                cy = y - (MAXPOOL - 1 - r);
                idx = r * MAXPOOL + c;
                inmap = (cx >= 0) && (cy >= 0);
                corner = (r >= MAXPOOL - m_ps) && (c >= MAXPOOL - m_ps);
`ifdef RENKON_POOLBUF_ZEROPAD_EN
                e[OFF_M + idx] = 1'b1;
                if (inmap) e[OFF_W + idx*DWIDTH +: DWIDTH] = img[cy][cx];
`else
                if (v && corner && inmap) begin
                    e[OFF_M + idx] = 1'b1;
                    e[OFF_W + idx*DWIDTH +: DWIDTH] = img[cy][cx];
                end
`endif
            end
        end
        return e;
    endfunction

    // driver tasks
    task automatic do_reset(input bit with_pix, input int val);
        xrst = 1'b1;
        bus.pixel_valid = with_pix;
        bus.pixel_in = pix_t'(val);
        m_active = 0;
        m_last = reset_entry();
        exp_q.push_back(m_last);
        acc = 1'b1;
        @(posedge clk); #1;
        xrst = 1'b0;
        bus.pixel_valid = 1'b0;
        acc = 1'b0;
    endtask

    task automatic start_map(input int fs, input int ps, input bit with_pix, input int val);
        logic [EW-1:0] e;
        bus.buf_feat_req = 1'b1;
        bus.w_fea_size = LWIDTH'(fs);
        bus.pool_size = LWIDTH'(ps);
        bus.pixel_valid = with_pix;
        bus.pixel_in = pix_t'(val);
        if (fs != 0) begin
            m_active = 1;
            m_fs = (fs > MAXFEA) ? MAXFEA : fs;
            m_ps = (ps < 1 || ps > MAXPOOL) ? MAXPOOL : ps;
            mx = 0;
            my = 0;
        end else begin
            m_active = 0;
        end
        e = m_last;
        e[1] = m_active;
        e[2] = 1'b0;
        m_last = e;
        exp_q.push_back(e);
        acc = 1'b1;
        @(posedge clk); #1;
        bus.buf_feat_req = 1'b0;
        bus.pixel_valid = 1'b0;
        acc = 1'b0;
    endtask

    task automatic send_pixel(input int val);
        logic [EW-1:0] e;
        bus.pixel_valid = 1'b1;
        bus.pixel_in = pix_t'(val);
        if (m_active) begin
            img[my][mx] = pix_t'(val);
            e = build_exp(mx, my);
            if (mx == m_fs - 1) begin
                mx = 0;
                if (my == m_fs - 1) begin
                    my = 0;
                    m_active = 0;
                end else begin
                    my++;
                end
            end else begin
                mx++;
            end
            e[1] = m_active;
        end else begin
            e = m_last;
            e[2] = 1'b0;
        end
        m_last = e;
        exp_q.push_back(e);
        acc = 1'b1;
        @(posedge clk); #1;
        bus.pixel_valid = 1'b0;
        acc = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_count(input int want, input string tag);
        @(negedge clk); #1;
        n_tests++;
        if (valid_cnt != want) begin
            n_fail++;
            $display("FAIL %s got %0d buf_valid pulses want %0d", tag, valid_cnt, want);
        end
    endtask

    task automatic check_entry(input logic [EW-1:0] e, input string tag);
        logic [NWIN-1:0]   m;
        logic [DWIDTH-1:0] got, want;
        bit bad;
        int bi;
        n_tests++;
        if (bus.buf_valid !== e[0]) begin
            n_fail++;
            $display("FAIL %s_valid t=%0t got %b want %b", tag, $time, bus.buf_valid, e[0]);
        end
        n_tests++;
        if (bus.buf_busy !== e[1]) begin
            n_fail++;
            $display("FAIL %s_busy t=%0t got %b want %b", tag, $time, bus.buf_busy, e[1]);
        end
        m = e[OFF_M +: NWIN];
        if (m != '0) begin
            n_tests++;
            bad = 0; bi = 0; got = '0; want = '0;
            for (int i = 0; i < NWIN; i++) begin
                if (m[i] && !bad && (bus.buf_feat[i*DWIDTH +: DWIDTH] !== e[OFF_W + i*DWIDTH +: DWIDTH])) begin
                    bad = 1;
                    bi = i;
                    got = bus.buf_feat[i*DWIDTH +: DWIDTH];
                    want = e[OFF_W + i*DWIDTH +: DWIDTH];
                end
            end
            if (bad) begin
                n_fail++;
                $display("FAIL %s_window t=%0t entry %0d got %0d want %0d",
                         tag, $time, bi, $signed(got), $signed(want));
            end
        end
    endtask

    // monitor: one output update per consumed stimulus edge
    initial begin : monitor
        logic s;
        logic [EW-1:0] e, last_e;
        last_e = reset_entry();
        forever begin
            @(posedge clk);
            s = acc;
            @(negedge clk);
            if (s) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_underflow t=%0t got output with no expectation want none", $time);
                end else begin
                    e = exp_q.pop_front();
                    check_entry(e, "out");
                    if (e[2] && bus.buf_valid === 1'b1) valid_cnt++;
                    last_e = e;
                end
            end else if (gap_chk) begin
                check_entry(last_e, "gap");
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end

    // stimulus
    initial begin
        xrst = 1'b1;
        bus.buf_feat_req = 1'b0;
        bus.w_fea_size = '0;
        bus.pool_size = '0;
        bus.pixel_valid = 1'b0;
        bus.pixel_in = '0;
        m_active = 0; m_fs = 0; m_ps = 1; mx = 0; my = 0;
        m_last = reset_entry();
        repeat (2) @(posedge clk);
        #1;
        do_reset(0, 0);

        // reset mid-stream, then pixels with no request
        start_map(4, 2, 0, 0);
        for (int i = 0; i < 10; i++) send_pixel(i);
        do_reset(1, 10);
        for (int i = 11; i < 14; i++) send_pixel(i);

        // 4x4 map, 2x2 window
        start_map(4, 2, 0, 0);
        valid_cnt = 0;
        for (int i = 0; i < 16; i++) send_pixel(i);
        expect_count(9, "s2_pulses");

        // 6x6 map, 3x3 window, gaps between pixels
        start_map(6, 3, 0, 0);
        valid_cnt = 0;
        gap_chk = 1'b1;
        for (int i = 0; i < 36; i++) begin
            send_pixel(i);
            idle(1);
        end
        gap_chk = 1'b0;
        expect_count(16, "s3_pulses");

        // oversized pool clamps to MAXPOOL; zero map size stays idle
        start_map(4, 7, 0, 0);
        valid_cnt = 0;
        for (int i = 0; i < 16; i++) send_pixel(100 + i);
        expect_count(4, "s4_pulses");
        start_map(0, 2, 0, 0);
        send_pixel(200);

        // restart mid-map with a colliding pixel
        start_map(4, 2, 0, 0);
        for (int i = 0; i < 7; i++) send_pixel(50 + i);
        start_map(4, 2, 1, 57);
        valid_cnt = 0;
        for (int i = 0; i < 16; i++) send_pixel(i);
        expect_count(9, "s5_pulses");

        // 3x3 window over a 4x4 map with negative pixels
        start_map(4, 3, 0, 0);
        valid_cnt = 0;
        for (int i = 0; i < 16; i++) send_pixel(i - 7);
        expect_count(4, "s6_pulses");

        idle(2);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
